// File: rtl/draw_rectangle.sv
// Streams the perimeter points of a rectangle: both vertical edges row by row, then both
// horizontal edges column by column. Define DRAW_RECTANGLE_RESTART_EN to let _start restart a run.
module draw_rectangle (
  input  logic        _clock,
  input  logic        _reset_n,
  input  logic        _start,
  input  logic [31:0] s_x,
  input  logic [31:0] s_y,
  input  logic [31:0] height,
  input  logic [31:0] width,
  output logic [31:0] _out0,
  output logic [31:0] _out1,
  output logic        _valid,
  output logic        _done
);

  typedef enum logic [1:0] {StIdle, StVert, StHorz} state_e;

`ifdef DRAW_RECTANGLE_RESTART_EN
  localparam bit RestartEn = 1'b1;
`else
  localparam bit RestartEn = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [31:0] i_q, i_d;
  // Selects which of the two points for the current i is emitted next.
  logic        side_q, side_d;
  logic [31:0] sx_q, sx_d;
  logic [31:0] sy_q, sy_d;
  logic [31:0] h_q, h_d;
  logic [31:0] w_q, w_d;
  logic [31:0] out0_q, out0_d;
  logic [31:0] out1_q, out1_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        take_start;

  assign take_start = _start && ((state_q == StIdle) || RestartEn);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    side_d  = side_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    h_d     = h_q;
    w_d     = w_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
    valid_d = 1'b0;
    done_d  = 1'b1;

    if (take_start) begin
      sx_d = s_x;
      sy_d = s_y;
      h_d  = height;
      w_d  = width;
      i_d  = '0;
      if ((height != '0) && (width != '0)) begin
        // First point goes out straight from the inputs so it is valid one cycle after start.
        out0_d  = s_x;
        out1_d  = s_y;
        valid_d = 1'b1;
        done_d  = 1'b0;
        state_d = StVert;
        side_d  = 1'b1;
      end else begin
        state_d = StIdle;
        side_d  = 1'b0;
      end
    end else begin
      case (state_q)
        StIdle: ;
        StVert: begin
          valid_d = 1'b1;
          done_d  = 1'b0;
          out0_d  = side_q ? (sx_q + w_q - 32'd1) : sx_q;
          out1_d  = sy_q + i_q;
          if (side_q) begin
            side_d = 1'b0;
            if (i_q == h_q - 32'd1) begin
              state_d = StHorz;
              i_d     = '0;
            end else begin
              i_d = i_q + 32'd1;
            end
          end else begin
            side_d = 1'b1;
          end
        end
        StHorz: begin
          valid_d = 1'b1;
          done_d  = 1'b0;
          out0_d  = sx_q + i_q;
          out1_d  = side_q ? (sy_q + h_q - 32'd1) : sy_q;
          if (side_q) begin
            side_d = 1'b0;
            if (i_q == w_q - 32'd1) begin
              state_d = StIdle;
              i_d     = '0;
            end else begin
              i_d = i_q + 32'd1;
            end
          end else begin
            side_d = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          i_d     = '0;
          side_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge _clock) begin
    if (!_reset_n) begin
      state_q <= StIdle;
      i_q     <= '0;
      side_q  <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      h_q     <= '0;
      w_q     <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      side_q  <= side_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      h_q     <= h_d;
      w_q     <= w_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign _out0  = out0_q;
  assign _out1  = out1_q;
  assign _valid = valid_q;
  assign _done  = done_q;

endmodule

// File: tb/tb_draw_rectangle.sv
// Scoreboard bench for draw_rectangle: the driver queues the expected perimeter points,
// a negedge monitor pops and compares every valid point.
module tb_draw_rectangle;

  logic        _clock = 1'b0;
  logic        _reset_n;
  logic        _start;
  logic [31:0] s_x, s_y, height, width;
  logic [31:0] _out0, _out1;
  logic        _valid, _done;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
  } pt_t;

  pt_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  bit  mon_en = 1'b0;

  draw_rectangle dut (
    ._clock  (_clock),
    ._reset_n(_reset_n),
    ._start  (_start),
    .s_x     (s_x),
    .s_y     (s_y),
    .height  (height),
    .width   (width),
    ._out0   (_out0),
    ._out1   (_out1),
    ._valid  (_valid),
    ._done   (_done)
  );

  always #5 _clock = ~_clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference order: both vertical edges per row, then both horizontal edges per column.
  function automatic int push_exp(input logic [31:0] sx, input logic [31:0] sy,
                                  input logic [31:0] h, input logic [31:0] w, input int limit);
    int  n = 0;
    pt_t p;
    if (h == 0 || w == 0) return 0;
    for (int unsigned i = 0; i < h; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (limit >= 0 && n >= limit) return n;
        p.x = (s == 1) ? sx + w - 32'd1 : sx;
        p.y = sy + i;
        exp_q.push_back(p);
        n++;
      end
    end
    for (int unsigned i = 0; i < w; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (limit >= 0 && n >= limit) return n;
        p.x = sx + i;
        p.y = (s == 1) ? sy + h - 32'd1 : sy;
        exp_q.push_back(p);
        n++;
      end
    end
    return n;
  endfunction

  initial begin
    pt_t e;
    forever begin
      @(negedge _clock);
      if (mon_en) begin
        check("done_vs_valid", {63'd0, _done}, {63'd0, !_valid});
        if (_valid) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_point: got (%0h,%0h), expected none", _out0, _out1);
          end else begin
            e = exp_q.pop_front();
            check("point", {_out0, _out1}, {e.x, e.y});
          end
        end
      end
    end
  end

  task automatic scramble();
    s_x    = $urandom;
    s_y    = $urandom;
    height = $urandom;
    width  = $urandom;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, {63'd0, _valid}, 64'd0);
    check({tag, "_done"}, {63'd0, _done}, 64'd1);
    check({tag, "_out"}, {_out0, _out1}, 64'd0);
  endtask

  // rs_at > 0 pulses _start again so that it is sampled rs_at edges after the first one.
  task automatic run(input logic [31:0] sx, input logic [31:0] sy, input logic [31:0] h,
                     input logic [31:0] w, input int rs_at, input logic [31:0] rx,
                     input logic [31:0] ry, input logic [31:0] rh, input logic [31:0] rw);
    int n;
    int waited = 0;
    @(negedge _clock);
    s_x = sx; s_y = sy; height = h; width = w;
    _start = 1'b1;
`ifdef DRAW_RECTANGLE_RESTART_EN
    if (rs_at > 0) n = push_exp(sx, sy, h, w, rs_at) + push_exp(rx, ry, rh, rw, -1);
    else n = push_exp(sx, sy, h, w, -1);
`else
    n = push_exp(sx, sy, h, w, -1);
`endif
    @(posedge _clock);
    #1;
    _start = 1'b0;
    scramble();
    if (rs_at > 0) begin
      repeat (rs_at - 1) @(posedge _clock);
      @(negedge _clock);
      s_x = rx; s_y = ry; height = rh; width = rw;
      _start = 1'b1;
      @(posedge _clock);
      #1;
      _start = 1'b0;
      scramble();
      waited = rs_at;
    end
    repeat (n - waited) @(posedge _clock);
    #3;
    check("drained", 64'(exp_q.size()), 64'd0);
    check("end_valid", {63'd0, _valid}, 64'd0);
    check("end_done", {63'd0, _done}, 64'd1);
    exp_q.delete();
  endtask

  initial begin
    int n_old;
    logic [31:0] rsx, rsy, rh, rw, rx, ry, rrh, rrw;
    int rs;
    _reset_n = 1'b0;
    _start   = 1'b0;
    scramble();
    repeat (2) @(posedge _clock);
    #3;
    check_idle_zero("reset");
    mon_en = 1'b1;
    @(negedge _clock);
    _reset_n = 1'b1;

    // Basic 3x4 rectangle, zero-sized, 1x1 and wrap-around cases.
    run(32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 0, 0, 0);
    run(32'd3, 32'd3, 32'd0, 32'd5, 0, 0, 0, 0, 0);
    run(32'd3, 32'd3, 32'd5, 32'd0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge _clock);
    run(32'd7, 32'd9, 32'd1, 32'd1, 0, 0, 0, 0, 0);
    run(32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 0, 0, 0, 0, 0);
    run(32'd5, 32'hFFFF_FFFE, 32'd4, 32'd1, 0, 0, 0, 0, 0);

    // Reset lands in the 5th cycle of a run: five points out, then nothing.
    @(negedge _clock);
    s_x = 32'd1; s_y = 32'd2; height = 32'd3; width = 32'd4;
    _start = 1'b1;
    void'(push_exp(32'd1, 32'd2, 32'd3, 32'd4, -1));
    @(posedge _clock);
    #1;
    _start = 1'b0;
    scramble();
    repeat (4) @(posedge _clock);
    #1;
    _reset_n = 1'b0;
    @(posedge _clock);
    #1;
    check("reset_midrun_left", 64'(exp_q.size()), 64'd9);
    exp_q.delete();
    #2;
    check_idle_zero("reset_midrun");
    @(negedge _clock);
    _reset_n = 1'b1;
    run(32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 0, 0, 0);

    // Second _start mid-run (ignored by default, restarts with the macro).
    run(32'd1, 32'd2, 32'd3, 32'd4, 6, 32'd10, 32'd20, 32'd2, 32'd2);

    for (int t = 0; t < 40; t++) begin
      rsx = $urandom; rsy = $urandom;
      rh  = 32'($urandom_range(0, 6));
      rw  = 32'($urandom_range(0, 6));
      n_old = (rh == 0 || rw == 0) ? 0 : int'(2 * rh + 2 * rw);
      rs = 0;
      if (n_old >= 2 && $urandom_range(0, 2) == 0) rs = $urandom_range(1, n_old - 1);
      rx = $urandom; ry = $urandom;
      rrh = 32'($urandom_range(1, 5));
      rrw = 32'($urandom_range(1, 5));
      run(rsx, rsy, rh, rw, rs, rx, ry, rrh, rrw);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge _clock);
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/draw_rectangle.md
DRAW_RECTANGLE -- requirements
Module: draw_rectangle

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; no other clock or reset exists.
REQ-002 _clock  input  1  rising-edge clock for all state.
REQ-003 _reset_n  input  1  synchronous active-low reset, sampled on rising _clock.
REQ-004 _start  input  1  start request, sampled on rising _clock.
REQ-005 s_x  input  32  unsigned x of rectangle top-left corner.
REQ-006 s_y  input  32  unsigned y of rectangle top-left corner.
REQ-007 height  input  32  unsigned rectangle height in pixels.
REQ-008 width  input  32  unsigned rectangle width in pixels.
REQ-009 _out0  output  32  x coordinate of the current perimeter point (registered).
REQ-010 _out1  output  32  y coordinate of the current perimeter point (registered).
REQ-011 _valid  output  1  high for exactly the cycles carrying a point on _out0/_out1.
REQ-012 _done  output  1  high when idle, low while a drawing is in progress.

Function
REQ-013 SHALL use states IDLE, VERT, HORZ; counter i is 32 bits.
REQ-014 IDLE with _start=1 SHALL latch s_x, s_y, height and width; later input changes do not affect the run.
REQ-015 After the latch, the next state SHALL be VERT with i=0 if height>0 and width>0; otherwise the block stays in IDLE.
REQ-016 VERT SHALL emit two points per i, one per cycle: (s_x, s_y+i), then (s_x+width-1, s_y+i), for i=0..height-1.
REQ-017 After VERT, the block SHALL enter HORZ with i=0.
REQ-018 HORZ SHALL emit (s_x+i, s_y), then (s_x+i, s_y+height-1), for i=0..width-1, one point per cycle.
REQ-019 After HORZ, the block SHALL return to IDLE.
REQ-020 The run SHALL emit exactly 2*height+2*width points with no gap cycles; duplicate corners are emitted as listed.
REQ-021 If _start is sampled high at rising edge N, the first point SHALL be valid in the cycle after edge N.
REQ-022 _done SHALL fall in that same cycle, stay low for the whole run, and rise in the cycle after the last point.
REQ-023 If height=0 or width=0, the block SHALL emit no points, keep _valid=0, and keep _done=1.
REQ-024 All coordinate arithmetic SHALL be 32-bit unsigned, wrapping modulo 2^32; there is no overflow flag.
REQ-025 When _valid=0, _out0 and _out1 SHALL hold their last values.
REQ-026 Without DRAW_RECTANGLE_RESTART_EN, _start SHALL be ignored while a run is in progress.

Reset
REQ-027 When _reset_n=0 at a rising edge, the block SHALL enter IDLE and set _out0=0, _out1=0, _valid=0, _done=1, i=0, and latched inputs=0.
REQ-028 Reset SHALL take priority over _start and SHALL abort a run in progress immediately; no further points are emitted.

Configuration
REQ-029 With DRAW_RECTANGLE_RESTART_EN defined, _start=1 during a run SHALL re-latch the inputs and restart from VERT i=0; its first point appears in the next cycle, and _done stays low.
REQ-030 Without DRAW_RECTANGLE_RESTART_EN, behaviour SHALL follow REQ-026.

Verification
REQ-031 Reset, then s_x=1, s_y=2, height=3, width=4, one-cycle _start.
- Required points: (1,2) (4,2) (1,3) (4,3) (1,4) (4,4) (1,2) (1,4) (2,2) (2,4) (3,2) (3,4) (4,2) (4,4).
- Points appear on 14 consecutive _valid cycles, the first one cycle after _start.
- _done is 0 during the run and 1 in the following cycle.
REQ-032 height=0, width=5, _start -> no _valid cycles; _done remains 1.
REQ-033 height=1, width=1, s_x=7, s_y=9 -> four points, all (7,9), then _done=1.
REQ-034 s_x=32'hFFFFFFFF, s_y=0, height=1, width=2 -> second point is (0,0) (wrap); 6 points total.
REQ-035 _reset_n=0 asserted in the 5th cycle of the REQ-031 run -> next cycle _valid=0, _done=1, outputs 0; a new _start then gives the full 14-point sequence.
REQ-036 _start pulsed again mid-run.
- Without the macro: it is ignored and exactly 14 points are emitted.
- With DRAW_RECTANGLE_RESTART_EN: the sequence restarts at (s_x,s_y) on the next cycle.
